// File: rtl/burst_rr_scheduler.sv
// burst_rr_scheduler
//   Shares one downstream beat port between NUM_REQ requesters. Picks a
//   winner round-robin, then locks the port to that winner until it flags
//   its last beat or MAX_BURST beats have been accepted.
//
// Ports
//   clk_i    clock
//   rst_ni   asynchronous active-low reset
//   flush_i  synchronous clear of all scheduler state (wins over a handshake)
//   req_i    per-requester beat request
//   last_i   per-requester end-of-burst flag (only the granted bit matters)
//   gnt_o    one-hot grant; beat taken when gnt_o[i] & ready_i
//   vld_o    beat presented downstream
//   ready_i  downstream accepts the beat
//   idx_o    index of the granted requester (rr_q when idle with no request)
//   busy_o   burst in progress
module burst_rr_scheduler #(
  parameter  int NUM_REQ   = 4,
  parameter  int MAX_BURST = 8,
  localparam int IDX_W     = $clog2(NUM_REQ)
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               flush_i,
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [NUM_REQ-1:0] last_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic               vld_o,
  input  logic               ready_i,
  output logic [IDX_W-1:0]   idx_o,
  output logic               busy_o
);

  localparam int CNT_W = $clog2(MAX_BURST + 1);

  typedef enum logic {IDLE, BURST} state_e;

  state_e           state_q, state_d;
  logic [IDX_W-1:0] rr_q, rr_d;
  logic [IDX_W-1:0] lock_q, lock_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [IDX_W-1:0] sel, cand, gidx, gidx_inc;
  logic             any_req, accept, ends;

  // Rotating priority search starting at rr_q. The candidate index wraps by
  // explicit compare so NUM_REQ need not be a power of two.
  always_comb begin
    sel     = rr_q;
    any_req = 1'b0;
    cand    = rr_q;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!any_req && req_i[cand]) begin
        sel     = cand;
        any_req = 1'b1;
      end
      cand = (cand == IDX_W'(NUM_REQ - 1)) ? '0 : cand + 1'b1;
    end
  end

  // In a burst only the locked requester is eligible; a dropped request
  // there is a bubble, not a release of the lock.
  always_comb begin
    gnt_o = '0;
    if (state_q == BURST) begin
      gidx  = lock_q;
      vld_o = req_i[lock_q];
    end else begin
      gidx  = sel;
      vld_o = any_req;
    end
    if (vld_o) gnt_o[gidx] = 1'b1;
  end

  assign idx_o    = gidx;
  assign busy_o   = (state_q == BURST);
  assign accept   = vld_o & ready_i;
  assign ends     = last_i[gidx] | (cnt_q == CNT_W'(MAX_BURST - 1));
  assign gidx_inc = (gidx == IDX_W'(NUM_REQ - 1)) ? '0 : gidx + 1'b1;

  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    lock_d  = lock_q;
    cnt_d   = cnt_q;
    if (flush_i) begin
      state_d = IDLE;
      rr_d    = '0;
      lock_d  = '0;
      cnt_d   = '0;
    end else if (accept) begin
      if (ends) begin
        state_d = IDLE;
        rr_d    = gidx_inc;
        cnt_d   = '0;
      end else begin
        state_d = BURST;
        lock_d  = gidx;
        cnt_d   = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      rr_q    <= '0;
      lock_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      lock_q  <= lock_d;
      cnt_q   <= cnt_d;
    end
  end

  a_gnt_onehot: assert property (@(posedge clk_i) disable iff (!rst_ni)
    $onehot0(gnt_o));
  a_vld_gnt: assert property (@(posedge clk_i) disable iff (!rst_ni)
    vld_o == (|gnt_o));
  a_cnt_cap: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (state_q == BURST) |-> (cnt_q <= CNT_W'(MAX_BURST - 1)));
  a_lock_rng: assert property (@(posedge clk_i) disable iff (!rst_ni)
    int'(lock_q) < NUM_REQ);

endmodule

// File: tb/tb_burst_rr_scheduler.sv
module tb_burst_rr_scheduler;

  logic       clk_i = 1'b0;
  logic       rst_ni;
  logic       flush_i;
  logic [3:0] req_i, last_i;
  logic       ready_i;

  logic [3:0] gnt4, gnt1;
  logic [2:0] gnt3;
  logic [1:0] idx4, idx3, idx1;
  logic       vld4, vld3, vld1, busy4, busy3, busy1;

  always #5 clk_i = ~clk_i;

  burst_rr_scheduler #(.NUM_REQ(4), .MAX_BURST(8)) d4 (
    .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_i), .req_i(req_i),
    .last_i(last_i), .gnt_o(gnt4), .vld_o(vld4), .ready_i(ready_i),
    .idx_o(idx4), .busy_o(busy4));

  burst_rr_scheduler #(.NUM_REQ(3), .MAX_BURST(8)) d3 (
    .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_i), .req_i(req_i[2:0]),
    .last_i(last_i[2:0]), .gnt_o(gnt3), .vld_o(vld3), .ready_i(ready_i),
    .idx_o(idx3), .busy_o(busy3));

  burst_rr_scheduler #(.NUM_REQ(4), .MAX_BURST(1)) d1 (
    .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_i), .req_i(req_i),
    .last_i(last_i), .gnt_o(gnt1), .vld_o(vld1), .ready_i(ready_i),
    .idx_o(idx1), .busy_o(busy1));

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model: who owns the port, where the rotation starts, and how
  // many beats the current owner has had.
  typedef struct {
    int n;
    int mb;
    int ptr;
    int owner;
    int beats;
    bit burst;
  } mstate_t;

  mstate_t m4, m3, m1;

  function automatic mstate_t minit(input int n, input int mb);
    mstate_t m;
    m.n = n; m.mb = mb; m.ptr = 0; m.owner = 0; m.beats = 0; m.burst = 0;
    return m;
  endfunction

  function automatic void mout(input mstate_t m, input logic [3:0] rq,
                               output int idx, output bit vld, output int gnt);
    if (m.burst) begin
      vld = rq[m.owner];
      idx = m.owner;
    end else begin
      vld = 0;
      idx = m.ptr;
      for (int k = 0; k < m.n; k++) begin
        int c;
        c = (m.ptr + k) % m.n;
        if (!vld && rq[c]) begin
          vld = 1;
          idx = c;
        end
      end
    end
    gnt = vld ? (1 << idx) : 0;
  endfunction

  function automatic mstate_t mnext(input mstate_t m, input bit fl,
                                    input logic [3:0] rq, input logic [3:0] lt,
                                    input bit rd);
    int idx, gnt;
    bit vld;
    mstate_t r;
    r = m;
    mout(m, rq, idx, vld, gnt);
    if (fl) begin
      r = minit(m.n, m.mb);
    end else if (vld && rd) begin
      if (lt[idx] || (m.beats + 1 == m.mb)) begin
        r.burst = 0;
        r.ptr   = (idx + 1) % m.n;
        r.beats = 0;
      end else begin
        r.burst = 1;
        r.owner = idx;
        r.beats = m.beats + 1;
      end
    end
    return r;
  endfunction

  task automatic chk_dut(input string tag, input mstate_t m, input int g,
                         input bit v, input int ix, input bit b);
    int eidx, egnt;
    bit evld;
    mout(m, req_i, eidx, evld, egnt);
    chk({tag, "_vld"}, v, evld);
    chk({tag, "_gnt"}, g, egnt);
    chk({tag, "_idx"}, ix, eidx);
    chk({tag, "_busy"}, b, m.burst);
  endtask

  // Drive one cycle's inputs (at posedge+1) and compare every DUT to its model.
  task automatic apply(input bit fl, input logic [3:0] rq, input logic [3:0] lt,
                       input bit rd);
    flush_i = fl; req_i = rq; last_i = lt; ready_i = rd;
    #2;
    chk_dut("d4", m4, int'(gnt4), vld4, int'(idx4), busy4);
    chk_dut("d3", m3, int'({1'b0, gnt3}), vld3, int'(idx3), busy3);
    chk_dut("d1", m1, int'(gnt1), vld1, int'(idx1), busy1);
  endtask

  task automatic tick();
    @(posedge clk_i);
    m4 = mnext(m4, flush_i, req_i, last_i, ready_i);
    m3 = mnext(m3, flush_i, req_i, last_i, ready_i);
    m1 = mnext(m1, flush_i, req_i, last_i, ready_i);
    #1;
  endtask

  // Asynchronous reset pulse in the middle of a cycle.
  task automatic do_reset();
    flush_i = 0; req_i = '0; last_i = '0; ready_i = 0;
    rst_ni = 0;
    #1;
    chk("async_rst_busy", busy4, 0);
    m4 = minit(4, 8); m3 = minit(3, 8); m1 = minit(4, 1);
    #2;
    rst_ni = 1;
    @(posedge clk_i);
    #1;
  endtask

  bit ever_busy1 = 0;
  always @(negedge clk_i) if (rst_ni && busy1) ever_busy1 <= 1'b1;

  typedef struct {
    logic [3:0] req;
    logic [3:0] last;
    bit         ready;
    int         idx4;
    int         idx3;
    bit         busy;
  } vec_t;

  vec_t tbl[12];

  initial begin
    // Fairness: all request single beats; then requester 0 runs a 3-beat burst.
    for (int i = 0; i < 8; i++)
      tbl[i] = '{req: 4'b1111, last: 4'b1111, ready: 1'b1,
                 idx4: i % 4, idx3: i % 3, busy: 1'b0};
    tbl[8]  = '{4'b0011, 4'b0000, 1'b1, 0, 0, 1'b0};
    tbl[9]  = '{4'b0011, 4'b0000, 1'b1, 0, 0, 1'b1};
    tbl[10] = '{4'b0011, 4'b0001, 1'b1, 0, 0, 1'b1};
    tbl[11] = '{4'b0011, 4'b0010, 1'b1, 1, 1, 1'b0};

    rst_ni = 0; flush_i = 0; req_i = '0; last_i = '0; ready_i = 0;
    m4 = minit(4, 8); m3 = minit(3, 8); m1 = minit(4, 1);
    repeat (2) @(posedge clk_i);
    #1;
    chk("rst_busy", busy4, 0);
    chk("rst_vld", vld4, 0);
    chk("rst_gnt", int'(gnt4), 0);
    chk("rst_idx", int'(idx4), 0);
    #3 rst_ni = 1;
    @(posedge clk_i);
    #1;

    apply(0, 4'b0000, 4'b0000, 1);
    chk("idle_norq_idx", int'(idx4), 0);
    tick();

    foreach (tbl[i]) begin
      apply(0, tbl[i].req, tbl[i].last, tbl[i].ready);
      chk($sformatf("tbl%0d_idx4", i), int'(idx4), tbl[i].idx4);
      chk($sformatf("tbl%0d_idx3", i), int'(idx3), tbl[i].idx3);
      chk($sformatf("tbl%0d_busy", i), busy4, tbl[i].busy);
      tick();
    end

    // Cap: requester 2 holds with no last -> exactly 8 beats, then 3.
    do_reset();
    apply(0, 4'b1100, 4'b0000, 1);
    chk("cap_first_idx", int'(idx4), 2);
    tick();
    for (int i = 1; i < 8; i++) begin
      apply(0, 4'b1111, 4'b0000, 1);
      chk("cap_idx", int'(idx4), 2);
      chk("cap_busy", busy4, 1);
      tick();
    end
    apply(0, 4'b1111, 4'b0000, 1);
    chk("cap_next_idx", int'(idx4), 3);
    chk("cap_end_busy", busy4, 0);
    tick();

    // Backpressure on requester 3's burst (one beat already taken).
    for (int i = 0; i < 5; i++) begin
      apply(0, 4'b1111, 4'b0000, 0);
      chk("bp_idx", int'(idx4), 3);
      chk("bp_gnt", int'(gnt4), 8);
      tick();
    end
    // Bubble: locked requester drops, others ignored.
    for (int i = 0; i < 2; i++) begin
      apply(0, 4'b0111, 4'b0000, 1);
      chk("bub_vld", vld4, 0);
      chk("bub_gnt", int'(gnt4), 0);
      chk("bub_busy", busy4, 1);
      tick();
    end
    // Frozen count: exactly 7 more beats finish the 8-beat cap.
    for (int i = 0; i < 7; i++) begin
      apply(0, 4'b1000, 4'b0000, 1);
      chk("res_idx", int'(idx4), 3);
      chk("res_busy", busy4, 1);
      tick();
    end
    apply(0, 4'b1111, 4'b0000, 0);
    chk("res_end_busy", busy4, 0);
    chk("res_end_idx", int'(idx4), 0);
    tick();

    // Flush on beat 4 of requester 1's burst.
    do_reset();
    for (int i = 0; i < 3; i++) begin
      apply(0, 4'b0010, 4'b0000, 1);
      tick();
    end
    apply(1, 4'b0010, 4'b0000, 1);
    tick();
    apply(0, 4'b1111, 4'b0000, 0);
    chk("flush_busy", busy4, 0);
    chk("flush_rr_idx", int'(idx4), 0);
    tick();

    // Async reset in the middle of a burst.
    apply(0, 4'b0010, 4'b0000, 1);
    tick();
    apply(0, 4'b0010, 4'b0000, 1);
    chk("pre_rst_busy", busy4, 1);
    tick();
    do_reset();
    apply(0, 4'b0000, 4'b0000, 0);
    chk("post_rst_vld", vld4, 0);
    chk("post_rst_idx", int'(idx4), 0);
    tick();

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      logic [3:0] rq, lt;
      for (int b = 0; b < 4; b++) begin
        rq[b] = ($urandom_range(0, 2) != 0);
        lt[b] = ($urandom_range(0, 3) == 0);
      end
      apply($urandom_range(0, 49) == 0, rq, lt, $urandom_range(0, 3) != 0);
      tick();
    end

    chk("mb1_never_busy", int'(ever_busy1), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
